// File: rtl/spart_rx.sv
// spart_rx: receive half of the SPART serial port.
// Deserialises 8N1 (LSB first) frames from the rxd line using the shared
// oversampling baud enable, and holds the last byte with an rda flag.
// Optional feature macro: SPART_RX_OVERRUN_EN adds an `overrun` output that
// flags a byte overwritten before the CPU read it.
//
// Handshake: rd_ack is a single-cycle pulse meaning "the CPU has read
// rx_data". It clears rda/framing_err (and overrun) on the next edge, but a
// byte load on that same edge takes priority. rx_data is never cleared by it.

module spart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 baud_en,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
`ifdef SPART_RX_OVERRUN_EN
  output logic                 overrun,
`endif
  output logic [2:0]           rx_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t               state;
  logic                 rxd_meta;
  logic                 rxd_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  assign rx_state = state;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Frame FSM: start detect, mid-bit sampling, byte load and rd_ack handling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
`ifdef SPART_RX_OVERRUN_EN
      overrun     <= 1'b0;
`endif
    end else begin
      // CPU read clears the flags; a load below overrides this.
      if (rd_ack) begin
        rda         <= 1'b0;
        framing_err <= 1'b0;
`ifdef SPART_RX_OVERRUN_EN
        overrun     <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          // Checked every clock so the start edge is caught promptly.
          if (!rxd_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end

        START: begin
          if (baud_en) begin
            if (tick_cnt == TICK_MID) begin
              if (!rxd_s) begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                // Line went back high before mid start bit: glitch.
                state    <= IDLE;
                tick_cnt <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (baud_en) begin
            if (tick_cnt == TICK_LAST) begin
              // Shift right so the first (LSB) bit ends up at bit 0.
              shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
              tick_cnt  <= '0;
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                state <= STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (baud_en) begin
            if (tick_cnt == TICK_LAST) begin
              rx_data     <= shift_reg;
              rda         <= 1'b1;
              framing_err <= ~rxd_s;
`ifdef SPART_RX_OVERRUN_EN
              // A simultaneous read does not clear a pending overrun.
              if (rda && !rd_ack) begin
                overrun <= 1'b1;
              end else begin
                overrun <= overrun;
              end
`endif
              tick_cnt    <= '0;
              state       <= rxd_s ? IDLE : WAIT_HIGH;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        WAIT_HIGH: begin
          // A held-low line yields a single framed byte, then waits here.
          if (rxd_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: directed bench for spart_rx (OVERSAMPLE 16, baud_en every
// 4 clk, so one bit period is 64 clk).

module tb_spart_rx;

  localparam int BIT_CLK = 64;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       baud_en;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic [2:0] rx_state;
`ifdef SPART_RX_OVERRUN_EN
  logic       overrun;
`endif

  int vectors;
  int miscompares;

  spart_rx #(
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .baud_en    (baud_en),
    .rd_ack     (rd_ack),
    .rx_data    (rx_data),
    .rda        (rda),
    .framing_err(framing_err),
`ifdef SPART_RX_OVERRUN_EN
    .overrun    (overrun),
`endif
    .rx_state   (rx_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud enable: one clk out of every four, driven on the falling edge.
  initial begin
    logic [1:0] baud_cnt;
    baud_cnt = 2'd0;
    baud_en  = 1'b0;
    forever begin
      @(negedge clk);
      baud_cnt = baud_cnt + 2'd1;
      baud_en  = (baud_cnt == 2'd0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start bit plus the first nbits data bits, LSB first.
  task automatic send_bits(input logic [7:0] d, input int nbits);
    rxd = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < nbits; i++) begin
      rxd = d[i];
      wait_clk(BIT_CLK);
    end
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(d, 8);
    rxd = 1'b1;
    wait_clk(BIT_CLK);
  endtask

  task automatic pulse_read();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  // Raise rd_ack for exactly the cycle in which the stop bit is sampled:
  // the 16th baud tick after STOP is entered.
  task automatic ack_on_load();
    int budget;
    int ticks;
    logic timed_out;
    budget    = 0;
    timed_out = 1'b0;
    while (rx_state != S_STOP && !timed_out) begin
      @(posedge clk);
      #1;
      budget++;
      if (budget > 2000) timed_out = 1'b1;
    end
    check("ack_wait_stop", {31'd0, timed_out}, 32'd0);
    if (!timed_out) begin
      ticks = 0;
      while (ticks < 15) begin
        @(posedge clk);
        if (baud_en) ticks++;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    rxd         = 1'b1;
    rd_ack      = 1'b0;

    // Reset / idle
    wait_clk(5);
    check("rst_state", {29'd0, rx_state}, {29'd0, S_IDLE});
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_clk(100);
      check("idle_rda", {31'd0, rda}, 32'd0);
      check("idle_ferr", {31'd0, framing_err}, 32'd0);
      check("idle_data", {24'd0, rx_data}, 32'h00);
    end

    // Basic receive of 8'hCC
    send_bits(8'hCC, 8);
    rxd = 1'b1;
    wait_clk(16);
    check("cc_rda_early", {31'd0, rda}, 32'd0);
    wait_clk(BIT_CLK - 16);
    check("cc_data", {24'd0, rx_data}, 32'hCC);
    check("cc_rda", {31'd0, rda}, 32'd1);
    check("cc_ferr", {31'd0, framing_err}, 32'd0);
    pulse_read();
    check("cc_rda_clr", {31'd0, rda}, 32'd0);
    check("cc_data_hold", {24'd0, rx_data}, 32'hCC);

    // Glitch rejection, then 8'hA5
    rxd = 1'b0;
    wait_clk(12);
    rxd = 1'b1;
    wait_clk(BIT_CLK);
    check("glitch_state", {29'd0, rx_state}, {29'd0, S_IDLE});
    check("glitch_rda", {31'd0, rda}, 32'd0);
    send_frame(8'hA5);
    check("a5_data", {24'd0, rx_data}, 32'hA5);
    check("a5_rda", {31'd0, rda}, 32'd1);
    check("a5_ferr", {31'd0, framing_err}, 32'd0);
    pulse_read();

    // Framing error: 8'h55, line held low 3 bit times
    send_bits(8'h55, 8);
    rxd = 1'b0;
    wait_clk(BIT_CLK);
    check("fe_data", {24'd0, rx_data}, 32'h55);
    check("fe_rda", {31'd0, rda}, 32'd1);
    check("fe_ferr", {31'd0, framing_err}, 32'd1);
    check("fe_state", {29'd0, rx_state}, {29'd0, S_WAIT_HIGH});
    pulse_read();
    wait_clk(2 * BIT_CLK - 1);
    rxd = 1'b1;
    wait_clk(BIT_CLK);
    check("fe_one_load", {31'd0, rda}, 32'd0);
    check("fe_idle", {29'd0, rx_state}, {29'd0, S_IDLE});
    send_frame(8'h0F);
    check("0f_data", {24'd0, rx_data}, 32'h0F);
    check("0f_rda", {31'd0, rda}, 32'd1);
    check("0f_ferr", {31'd0, framing_err}, 32'd0);
    pulse_read();

    // Back-to-back 8'h12, 8'h34 without a read
    send_frame(8'h12);
    check("b2b_data12", {24'd0, rx_data}, 32'h12);
`ifdef SPART_RX_OVERRUN_EN
    check("b2b_ovr0", {31'd0, overrun}, 32'd0);
`endif
    send_frame(8'h34);
    check("b2b_data34", {24'd0, rx_data}, 32'h34);
    check("b2b_rda", {31'd0, rda}, 32'd1);
`ifdef SPART_RX_OVERRUN_EN
    check("b2b_ovr1", {31'd0, overrun}, 32'd1);
`endif

    // Read coinciding with the load edge of 8'h56
    fork
      send_frame(8'h56);
      ack_on_load();
    join
    check("ack_load_data", {24'd0, rx_data}, 32'h56);
    check("ack_load_rda", {31'd0, rda}, 32'd1);
    check("ack_load_ferr", {31'd0, framing_err}, 32'd0);
`ifdef SPART_RX_OVERRUN_EN
    check("ack_load_ovr", {31'd0, overrun}, 32'd1);
`endif

    // Reset in the middle of 8'hF0
    send_bits(8'hF0, 4);
    rst = 1'b0;
    #1;
    check("mid_rst_data", {24'd0, rx_data}, 32'h00);
    check("mid_rst_rda", {31'd0, rda}, 32'd0);
    check("mid_rst_ferr", {31'd0, framing_err}, 32'd0);
    check("mid_rst_state", {29'd0, rx_state}, {29'd0, S_IDLE});
`ifdef SPART_RX_OVERRUN_EN
    check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
`endif
    rxd = 1'b1;
    wait_clk(5);
    rst = 1'b1;
    wait_clk(10);
    send_frame(8'h3C);
    check("3c_data", {24'd0, rx_data}, 32'h3C);
    check("3c_rda", {31'd0, rda}, 32'd1);
    check("3c_ferr", {31'd0, framing_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
